// File: rtl/mem_arb2.sv
// Two-port arbiter sharing a single-ported, 16-bit, byte-addressed memory
// between an instruction-fetch requester (read-only) and a data requester
// (read/write). Grants drive the memory combinationally; responses are
// registered so done follows the grant by exactly one cycle. Misaligned
// accesses are answered locally with err=1. Saturating per-port grant
// counters and a one-shot memory dump request are also maintained here.
module mem_arb2 #(
  parameter int DATA_PRIO = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic [15:0]      if_addr,
  output logic             if_done,
  output logic [15:0]      if_rdata,
  output logic             if_err,
  input  logic             d_req,
  input  logic             d_wr,
  input  logic [15:0]      d_addr,
  input  logic [15:0]      d_wdata,
  output logic             d_done,
  output logic [15:0]      d_rdata,
  output logic             d_err,
  input  logic             dump_req,
  output logic             mem_enable,
  output logic             mem_wr,
  output logic [15:0]      mem_addr,
  output logic [15:0]      mem_wdata,
  output logic             mem_createdump,
  input  logic [15:0]      mem_rdata,
  input  logic             mem_err,
  output logic [CNT_W-1:0] if_grants,
  output logic [CNT_W-1:0] d_grants
);

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Read data captured for a response: misaligned accesses and writes return 0.
  function automatic logic [15:0] rsp_data(input logic mis, input logic wr,
                                           input logic [15:0] rd);
    if (mis || wr) return 16'h0000;
    return rd;
  endfunction

  // Error captured for a response: misalignment is a local error, otherwise
  // the memory's own error flag is reported.
  function automatic logic rsp_err(input logic mis, input logic merr);
    return mis | merr;
  endfunction

  logic             r_if_done;
  logic [15:0]      r_if_rdata;
  logic             r_if_err;
  logic             r_d_done;
  logic [15:0]      r_d_rdata;
  logic             r_d_err;
  logic             r_last_d;
  logic             r_dump_pend;
  logic [CNT_W-1:0] r_if_grants;
  logic [CNT_W-1:0] r_d_grants;

  logic             w_if_elig;
  logic             w_d_elig;
  logic             w_gnt_if;
  logic             w_gnt_d;
  logic             w_if_mis;
  logic             w_d_mis;
  logic             w_if_go;
  logic             w_d_go;
  logic             w_wr_now;
  logic             w_dump_fire;

  // A port is eligible when requesting and not in its own done cycle, so a
  // held request cannot be granted again before the requester sees done.
  assign w_if_elig = if_req & ~r_if_done;
  assign w_d_elig  = d_req  & ~r_d_done;
  assign w_if_mis  = if_addr[0];
  assign w_d_mis   = d_addr[0];

  // Pick at most one winner per cycle: fixed data priority, or round-robin
  // against the port granted last when DATA_PRIO is 0.
  always_comb begin
    w_gnt_if = 1'b0;
    w_gnt_d  = 1'b0;
    if (w_if_elig && w_d_elig) begin
      if (DATA_PRIO != 0) begin
        w_gnt_d = 1'b1;
      end else if (r_last_d) begin
        w_gnt_if = 1'b1;
      end else begin
        w_gnt_d = 1'b1;
      end
    end else begin
      w_gnt_if = w_if_elig;
      w_gnt_d  = w_d_elig;
    end
  end

  // Only aligned grants reach the memory; misaligned ones are answered locally.
  assign w_if_go  = w_gnt_if & ~w_if_mis;
  assign w_d_go   = w_gnt_d  & ~w_d_mis;
  assign w_wr_now = ~rst & w_d_go & d_wr;

  // Combinational memory drive in the grant cycle; quiet while in reset so
  // the memory's own reset load cannot be disturbed by a stray write.
  always_comb begin
    mem_enable = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = 16'h0000;
    mem_wdata  = 16'h0000;
    if (!rst) begin
      if (w_if_go) begin
        mem_enable = 1'b1;
        mem_addr   = if_addr;
      end else if (w_d_go) begin
        mem_enable = 1'b1;
        mem_addr   = d_addr;
        mem_wr     = d_wr;
        mem_wdata  = d_wr ? d_wdata : 16'h0000;
      end
    end
  end

  // The dump fires on the first pending cycle that carries no memory write.
  assign w_dump_fire    = ~rst & r_dump_pend & ~w_wr_now;
  assign mem_createdump = w_dump_fire;

  // ---- grant cycle -> response cycle ----
  // Fetch response registers: done pulses once per grant, data/err hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_if_done  <= 1'b0;
      r_if_rdata <= 16'h0000;
      r_if_err   <= 1'b0;
    end else begin
      r_if_done <= w_gnt_if;
      if (w_gnt_if) begin
        r_if_rdata <= rsp_data(w_if_mis, 1'b0, mem_rdata);
        r_if_err   <= rsp_err(w_if_mis, mem_err);
      end
    end
  end

  // Data response registers: writes return zero read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_d_done  <= 1'b0;
      r_d_rdata <= 16'h0000;
      r_d_err   <= 1'b0;
    end else begin
      r_d_done <= w_gnt_d;
      if (w_gnt_d) begin
        r_d_rdata <= rsp_data(w_d_mis, d_wr, mem_rdata);
        r_d_err   <= rsp_err(w_d_mis, mem_err);
      end
    end
  end

  // Round-robin pointer (1 = data granted last) moves only on a grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_d <= 1'b1;
    end else if (w_gnt_if || w_gnt_d) begin
      r_last_d <= w_gnt_d;
    end
  end

  // Dump pending flag: set by a request, cleared when the dump fires; a
  // request arriving while already pending folds into the same dump.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dump_pend <= 1'b0;
    end else if (w_dump_fire) begin
      r_dump_pend <= 1'b0;
    end else if (dump_req) begin
      r_dump_pend <= 1'b1;
    end
  end

  // Saturating grant counters, misaligned grants included.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_if_grants <= '0;
      r_d_grants  <= '0;
    end else begin
      if (w_gnt_if) r_if_grants <= sat_inc(r_if_grants);
      if (w_gnt_d)  r_d_grants  <= sat_inc(r_d_grants);
    end
  end

  assign if_done   = r_if_done;
  assign if_rdata  = r_if_rdata;
  assign if_err    = r_if_err;
  assign d_done    = r_d_done;
  assign d_rdata   = r_d_rdata;
  assign d_err     = r_d_err;
  assign if_grants = r_if_grants;
  assign d_grants  = r_d_grants;

endmodule
